// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - per-bit switch synchronizer and debouncer with edge pulses
//
// Purpose: Synchronizes raw board switch levels and accepts a new level per bit
//          only after it has differed from the current debounced level for
//          STABLE_TICKS consecutive prescaler ticks. The module emits registered
//          rise/fall pulses and a combined changed pulse.
// Ports:
//   clk       - clock; all flops update on its rising edge
//   reset_n   - asynchronous active-low reset
//   sw_raw    - asynchronous switch levels, WIDTH bits
//   sw_stable - debounced levels, WIDTH bits (registered)
//   rise      - one-cycle pulse per bit on a 0->1 acceptance (registered)
//   fall      - one-cycle pulse per bit on a 1->0 acceptance (registered)
//   changed   - one-cycle pulse when any bit of rise or fall is set (registered)

`timescale 1ns/1ps

module switch_debounce #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [PW-1:0]            presc_q, presc_d;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic                     changed_q, changed_d;

  // With TICK_DIV = 1 the counter is stuck at 0 == TICK_LAST, so tick is
  // high every cycle.
  assign tick    = (presc_q == TICK_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        // Any agreement with the accepted level discards progress.
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // Pulses are registered alongside the new level so they line up with it.
    rise_d    = stable_d & ~stable_q;
    fall_d    = ~stable_d & stable_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sw_raw;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_stable = stable_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign changed   = changed_q;

endmodule
